// File: rtl/wb_dma_copy.sv
// Wishbone classic block-copy initiator: one single read then one single write per word,
// with a per-bus-cycle ack timeout that aborts the job and raises a sticky error flag.
module wb_dma_copy #(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_SEL_WIDTH   = 4,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     start_i,
    input  logic [WB_ADDR_WIDTH-1:0] src_addr_i,
    input  logic [WB_ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]     len_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     wb_we_o,
    output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
    output logic                     wb_stb_o,
    output logic                     wb_cyc_o,
    input  logic                     wb_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WB_ADDR_WIDTH-1:0] STRIDE = WB_ADDR_WIDTH'(WB_DATA_WIDTH / 8);
    localparam logic [WB_ADDR_WIDTH-1:0] ALIGN_MASK = ~(WB_ADDR_WIDTH'(WB_SEL_WIDTH) - WB_ADDR_WIDTH'(1));

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RD_GAP = 3'd2,
        WR     = 3'd3,
        WR_GAP = 3'd4,
        FIN    = 3'd5
    } state_t;

    state_t                   state_r, state_s;
    logic [WB_ADDR_WIDTH-1:0] src_r, src_s, dst_r, dst_s, addr_r, addr_s;
    logic [LEN_WIDTH-1:0]     rem_r, rem_s;
    logic [WB_DATA_WIDTH-1:0] data_r, data_s;
    logic [CNT_W-1:0]         cnt_r, cnt_s;
    logic                     err_r, err_s;
    logic                     stb_r, stb_s, we_r, we_s, done_r, done_s, busy_r, busy_s;
    logic [WB_SEL_WIDTH-1:0]  sel_r, sel_s;

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, datapath updates and next values of the registered bus outputs.
    always_comb begin
        state_s = state_r;
        src_s   = src_r;
        dst_s   = dst_r;
        rem_s   = rem_r;
        data_s  = data_r;
        cnt_s   = '0;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    src_s   = src_addr_i & ALIGN_MASK;
                    dst_s   = dst_addr_i & ALIGN_MASK;
                    rem_s   = len_i;
                    err_s   = 1'b0;
                    state_s = (len_i == '0) ? FIN : RD;
                end else begin
                    state_s = IDLE;
                end
            end
            RD, WR: begin
                // An ack on the expiry edge still wins over the timeout.
                if (wb_ack_i) begin
                    if (state_r == RD) begin
                        data_s  = wb_data_i;
                        state_s = RD_GAP;
                    end else begin
                        src_s   = src_r + STRIDE;
                        dst_s   = dst_r + STRIDE;
                        rem_s   = rem_r - LEN_WIDTH'(1);
                        state_s = WR_GAP;
                    end
                end else if (cnt_r == TIMEOUT_LAST) begin
                    err_s   = 1'b1;
                    state_s = FIN;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            RD_GAP:  state_s = WR;
            WR_GAP:  state_s = (rem_r == '0) ? FIN : RD;
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase

        stb_s  = (state_s == RD) || (state_s == WR);
        we_s   = (state_s == WR);
        sel_s  = stb_s ? {WB_SEL_WIDTH{1'b1}} : '0;
        done_s = (state_s == FIN);
        busy_s = (state_s == RD) || (state_s == RD_GAP) || (state_s == WR) || (state_s == WR_GAP);
        if (state_s == RD) begin
            addr_s = src_s;
        end else if (state_s == WR) begin
            addr_s = dst_s;
        end else begin
            addr_s = addr_r;
        end
    end

    // Datapath and registered bus/status outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            src_r  <= '0;
            dst_r  <= '0;
            rem_r  <= '0;
            data_r <= '0;
            cnt_r  <= '0;
            err_r  <= 1'b0;
            addr_r <= '0;
            stb_r  <= 1'b0;
            we_r   <= 1'b0;
            sel_r  <= '0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            src_r  <= src_s;
            dst_r  <= dst_s;
            rem_r  <= rem_s;
            data_r <= data_s;
            cnt_r  <= cnt_s;
            err_r  <= err_s;
            addr_r <= addr_s;
            stb_r  <= stb_s;
            we_r   <= we_s;
            sel_r  <= sel_s;
            done_r <= done_s;
            busy_r <= busy_s;
        end
    end

    assign wb_addr_o = addr_r;
    assign wb_data_o = data_r;
    assign wb_we_o   = we_r;
    assign wb_sel_o  = sel_r;
    assign wb_stb_o  = stb_r;
    assign wb_cyc_o  = stb_r;
    assign busy_o    = busy_r;
    assign done_o    = done_r;
    assign err_o     = err_r;

endmodule
